// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard / flush unit.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [REG_ADDR_W_DEF-1:0] REG_X0 = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hazState_t;

endpackage

// File: rtl/hazard_cmp.sv
// Combinational load-use compare: EX load destination against the ID sources,
// with x0 excluded and each operand qualified by its use flag.
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  memRead,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  usesRs1,
  input  logic                  usesRs2,
  output logic                  hazard
);

  logic rdValid;
  logic hitRs1;
  logic hitRs2;

  assign rdValid = (rd != REG_ADDR_W'(REG_X0));
  assign hitRs1  = usesRs1 && (rd == rs1);
  assign hitRs2  = usesRs2 && (rd == rs2);
  assign hazard  = memRead && rdValid && (hitRs1 || hitRs2);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall FSM with branch-flush override for the ID stage.
// Optional perf counters (Stall_Cycles, Flush_Events) under HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRd,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs1,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs2,
  input  logic                  IF_ID_UsesRs1,
  input  logic                  IF_ID_UsesRs2,
  input  logic                  EX_BranchTaken,
  output logic                  PC_Write,
  output logic                  IFID_Write,
  output logic                  MUX_Write,
  output logic                  IFID_Flush,
  output logic                  IDEX_Flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      Stall_Cycles,
  output logic [CNT_W-1:0]      Flush_Events
`endif
);

  localparam int CW = $clog2(LOAD_LATENCY + 1);

  if (LOAD_LATENCY < 1 || CNT_W < 1) begin : gBadParam
    $error("hazard_stall_ctrl: LOAD_LATENCY and CNT_W must be >= 1");
  end

  hazState_t     state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic          hazard;
  logic          writeEn;

  hazard_cmp #(
    .REG_ADDR_W(REG_ADDR_W)
  ) uCmp (
    .memRead (ID_EX_MemRead),
    .rd      (ID_EX_RegisterRd),
    .rs1     (IF_ID_RegisterRs1),
    .rs2     (IF_ID_RegisterRs2),
    .usesRs1 (IF_ID_UsesRs1),
    .usesRs2 (IF_ID_UsesRs2),
    .hazard  (hazard)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // The first stall cycle is spent in IDLE, so STALL covers the remaining LOAD_LATENCY-1.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    writeEn    = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    if (reset) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else if (EX_BranchTaken) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
      stateNext  = IDLE;
      cntNext    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hazard) begin
            writeEn = 1'b0;
            if (LOAD_LATENCY > 1) begin
              stateNext = STALL;
              cntNext   = CW'(LOAD_LATENCY - 1);
            end
          end
        end
        STALL: begin
          writeEn = 1'b0;
          cntNext = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign PC_Write   = writeEn;
  assign IFID_Write = writeEn;
  assign MUX_Write  = writeEn;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      Stall_Cycles <= '0;
      Flush_Events <= '0;
    end else begin
      if (!PC_Write) Stall_Cycles <= Stall_Cycles + CNT_W'(1);
      if (IFID_Flush) Flush_Events <= Flush_Events + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl at LOAD_LATENCY 1, 3 and 4.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rd, rs1, rs2;
  logic       memRead, usesRs1, usesRs2, branch;

  logic pcW1, ifW1, muW1, ifF1, idF1;
  logic pcW3, ifW3, muW3, ifF3, idF3;
  logic pcW4, ifW4, muW4, ifF4, idF4;

  int errCnt = 0;
  int chkCnt = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
  logic [3:0]  stall1, flush1;
  logic [31:0] stall3, flush3, stall4, flush4;
`endif

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .ID_EX_RegisterRd(rd), .ID_EX_MemRead(memRead),
    .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2), .IF_ID_UsesRs1(usesRs1),
    .IF_ID_UsesRs2(usesRs2), .EX_BranchTaken(branch), .PC_Write(pcW1),
    .IFID_Write(ifW1), .MUX_Write(muW1), .IFID_Flush(ifF1), .IDEX_Flush(idF1)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Cycles(stall1), .Flush_Events(flush1)
`endif
  );

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .CNT_W(32)) u3 (
    .clk(clk), .reset(reset), .ID_EX_RegisterRd(rd), .ID_EX_MemRead(memRead),
    .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2), .IF_ID_UsesRs1(usesRs1),
    .IF_ID_UsesRs2(usesRs2), .EX_BranchTaken(branch), .PC_Write(pcW3),
    .IFID_Write(ifW3), .MUX_Write(muW3), .IFID_Flush(ifF3), .IDEX_Flush(idF3)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Cycles(stall3), .Flush_Events(flush3)
`endif
  );

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(4), .CNT_W(32)) u4 (
    .clk(clk), .reset(reset), .ID_EX_RegisterRd(rd), .ID_EX_MemRead(memRead),
    .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2), .IF_ID_UsesRs1(usesRs1),
    .IF_ID_UsesRs2(usesRs2), .EX_BranchTaken(branch), .PC_Write(pcW4),
    .IFID_Write(ifW4), .MUX_Write(muW4), .IFID_Flush(ifF4), .IDEX_Flush(idF4)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Cycles(stall4), .Flush_Events(flush4)
`endif
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs just after the edge, then wait to the sampling point.
  task automatic drive(input logic rst, input logic mr, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic u1b, input logic u2b, input logic br);
    @(posedge clk);
    #1;
    reset = rst; memRead = mr; rd = d; rs1 = s1; rs2 = s2;
    usesRs1 = u1b; usesRs2 = u2b; branch = br;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hazRs1();
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic doReset();
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    checkEq("rst_w1", {pcW1, ifW1, muW1}, 3'b111);
    checkEq("rst_f1", {ifF1, idF1}, 2'b00);
    checkEq("rst_w3", {pcW3, ifW3, muW3}, 3'b111);
  endtask

  initial begin
    reset = 1'b1; memRead = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
    usesRs1 = 1'b0; usesRs2 = 1'b0; branch = 1'b0;

    // 1: single-cycle stall at LOAD_LATENCY=1
    doReset();
    hazRs1();
    checkEq("t1_stall", {pcW1, ifW1, muW1}, 3'b000);
    checkEq("t1_noflush", {ifF1, idF1}, 2'b00);
    idle();
    checkEq("t1_resume", {pcW1, ifW1, muW1}, 3'b111);

    // 2: three-cycle stall; compare ignored while stalling
    doReset();
    hazRs1();
    checkEq("t2_c1", {pcW3, ifW3, muW3}, 3'b000);
    hazRs1();
    checkEq("t2_c2", {pcW3, ifW3, muW3}, 3'b000);
    idle();
    checkEq("t2_c3_ignore", {pcW3, ifW3, muW3}, 3'b000);
    idle();
    checkEq("t2_c4_idle", {pcW3, ifW3, muW3}, 3'b111);

    // 2b: back-to-back hazard re-evaluated right after leaving STALL
    doReset();
    repeat (3) hazRs1();
    hazRs1();
    checkEq("t2b_rehaz", {pcW3, ifW3, muW3}, 3'b000);
    idle();
    checkEq("t2b_stall2", {pcW3, ifW3, muW3}, 3'b000);

    // 3: x0 exclusion and use qualifiers
    doReset();
    drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    checkEq("t3_x0_l1", {pcW1, ifW1, muW1}, 3'b111);
    checkEq("t3_x0_l3", {pcW3, ifW3, muW3}, 3'b111);
    drive(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    checkEq("t3_rs2_unused", {pcW1, ifW1, muW1}, 3'b111);
    drive(1'b0, 1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b1, 1'b0);
    checkEq("t3_rs1_unused", {pcW1, ifW1, muW1}, 3'b111);
    drive(1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
    checkEq("t3_noload", {pcW1, ifW1, muW1}, 3'b111);
    drive(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0);
    checkEq("t3_rs2_hit", {pcW1, ifW1, muW1}, 3'b000);

    // 4: branch in second stall cycle flushes and returns to IDLE
    doReset();
    hazRs1();
    checkEq("t4_c1", {pcW3, ifW3, muW3}, 3'b000);
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b1, 1'b1);
    checkEq("t4_br_w", {pcW3, ifW3, muW3}, 3'b111);
    checkEq("t4_br_f", {ifF3, idF3}, 2'b11);
    checkEq("t4_same_cyc_w", {pcW1, ifW1, muW1}, 3'b111);
    checkEq("t4_same_cyc_f", {ifF1, idF1}, 2'b11);
    idle();
    checkEq("t4_after_w", {pcW3, ifW3, muW3}, 3'b111);
    checkEq("t4_after_f", {ifF3, idF3}, 2'b00);

    // 5: reset in stall cycle 2 aborts the stall
    doReset();
    hazRs1();
    checkEq("t5_c1", {pcW4, ifW4, muW4}, 3'b000);
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b1, 1'b0);
    checkEq("t5_rst_w", {pcW4, ifW4, muW4}, 3'b111);
    checkEq("t5_rst_f", {ifF4, idF4}, 2'b00);
    idle();
    checkEq("t5_idle", {pcW4, ifW4, muW4}, 3'b111);

`ifdef HAZARD_PERF_CNT_EN
    // 6: 4-bit counters wrap after 17 stall cycles
    doReset();
    hazRs1();
    checkEq("t6_clr", stall1, 32'd0);
    repeat (16) hazRs1();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkEq("t6_stall_wrap", stall1, 32'd1);
    checkEq("t6_flush_pre", flush1, 32'd0);
    idle();
    checkEq("t6_flush", flush1, 32'd1);
    checkEq("t6_stall_hold", stall1, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
